// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel: synchronise/debounce/edge-detect two buttons, run the
// IDLE/RUN/PAUSE/LAP state machine and mux live or lap-frozen digits to the display.
// Optional: define STOPWATCH_AUTOSTOP_EN to pause automatically when the count reaches 99.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 250000,
  parameter int DB_W      = 18
) (
  input  logic       clk,
  input  logic       res,
  input  logic       btn_ss,
  input  logic       btn_lc,
  input  logic [3:0] d1_in,
  input  logic [3:0] d0_in,
  output logic       go,
  output logic       clr,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Bit 0 carries start/stop, bit 1 carries lap/clear through every stage.
  logic [1:0] btn_raw;
  logic [1:0] sync_p0, sync_p1;
  logic [1:0] stable_p2;
  logic [1:0] stable_p3, pulse_p3;
  logic       ss_p, lc_p;
  logic       at_max;

  state_t     state_q, state_nxt;
  logic       clr_nxt, lap_cap;
  logic [3:0] lap_d1, lap_d0;

  assign btn_raw = {btn_lc, btn_ss};

  // Stage p0/p1: two-flop synchroniser on the raw buttons
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: a level is accepted only after DB_CYCLES consecutive differing samples
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic            stable;

    always_ff @(posedge clk or posedge res) begin
      if (res) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (sync_p1[i] == stable) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        stable <= sync_p1[i];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign stable_p2[i] = stable;
  end

  // Stage p3: registered rising-edge pulse, one cycle per accepted press
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      stable_p3 <= '0;
      pulse_p3  <= '0;
    end else begin
      stable_p3 <= stable_p2;
      pulse_p3  <= stable_p2 & ~stable_p3;
    end
  end

  assign ss_p = pulse_p3[0];
  assign lc_p = pulse_p3[1];

`ifdef STOPWATCH_AUTOSTOP_EN
  assign at_max = (d1_in == 4'd9) && (d0_in == 4'd9);
`else
  assign at_max = 1'b0;
`endif

  // Start/stop always wins over lap/clear and over the autostop condition.
  always_comb begin
    state_nxt = state_q;
    clr_nxt   = 1'b0;
    lap_cap   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_p) state_nxt = RUN;
        else if (lc_p) clr_nxt = 1'b1;
      end
      RUN: begin
        if (ss_p || at_max) begin
          state_nxt = PAUSE;
        end else if (lc_p) begin
          state_nxt = LAP;
          lap_cap   = 1'b1;
        end
      end
      LAP: begin
        if (ss_p || at_max) state_nxt = PAUSE;
        else if (lc_p) state_nxt = RUN;
      end
      PAUSE: begin
        if (ss_p) begin
          state_nxt = RUN;
        end else if (lc_p) begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p4: state, counter controls and lap snapshot; reset leaves one clear cycle
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      go      <= 1'b0;
      clr     <= 1'b1;
      lap_d1  <= 4'd0;
      lap_d0  <= 4'd0;
    end else begin
      state_q <= state_nxt;
      go      <= (state_nxt == RUN) || (state_nxt == LAP);
      clr     <= clr_nxt;
      if (lap_cap) begin
        lap_d1 <= d1_in;
        lap_d0 <= d0_in;
      end
    end
  end

  assign state = state_q;
  assign disp1 = (state_q == LAP) ? lap_d1 : d1_in;
  assign disp0 = (state_q == LAP) ? lap_d0 : d0_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce window; expected
// outputs are queued as each step is driven and popped when sampled.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int DB_CYCLES = 4;
  localparam int DB_W      = 4;

  logic       clk = 1'b0;
  logic       res;
  logic       btn_ss, btn_lc;
  logic [3:0] d1_in, d0_in;
  logic       go, clr;
  logic [3:0] disp1, disp0;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [11:0] v;
  } exp_t;

  exp_t sb[$];

  stopwatch_ctrl #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) dut (
    .clk    (clk),
    .res    (res),
    .btn_ss (btn_ss),
    .btn_lc (btn_lc),
    .d1_in  (d1_in),
    .d0_in  (d0_in),
    .go     (go),
    .clr    (clr),
    .disp1  (disp1),
    .disp0  (disp0),
    .state  (state)
  );

  always #20 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic g,
                            input logic c, input logic [3:0] e1, input logic [3:0] e0);
    exp_t e;
    e.tag = tag;
    e.v   = {st, g, c, e1, e0};
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [11:0] obs;
    obs = {state, go, clr, disp1, disp0};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h with nothing expected", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s: observed st=%0d go=%b clr=%b disp=%h%h expected st=%0d go=%b clr=%b disp=%h%h",
             e.tag, obs[11:10], obs[9], obs[8], obs[7:4], obs[3:0],
             e.v[11:10], e.v[9], e.v[8], e.v[7:4], e.v[3:0]);
    end
  endtask

  task automatic press(input logic ss, input logic lc);
    btn_ss = ss;
    btn_lc = lc;
    tick(10);
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    tick(10);
  endtask

  initial begin
    res    = 1'b1;
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    d1_in  = 4'd0;
    d0_in  = 4'd0;

    expect_out("reset_state", 2'd0, 1'b0, 1'b1, 4'd0, 4'd0);
    tick(2);
    check_out();

    d1_in = 4'd2; d0_in = 4'd1;
    expect_out("reset_disp", 2'd0, 1'b0, 1'b1, 4'd2, 4'd1);
    #1;
    check_out();

    // Release: clr stays high until the first edge, then drops for good.
    res = 1'b0;
    expect_out("release_clr_hi", 2'd0, 1'b0, 1'b1, 4'd2, 4'd1);
    expect_out("release_clr_lo", 2'd0, 1'b0, 1'b0, 4'd2, 4'd1);
    expect_out("release_clr_1cy", 2'd0, 1'b0, 1'b0, 4'd2, 4'd1);
    #1;
    check_out();
    tick(1);
    check_out();
    tick(1);
    check_out();

    // Start latency: 2 sync + 4 debounce + 1 edge + 1 state edges.
    expect_out("ss_latency_pre", 2'd0, 1'b0, 1'b0, 4'd2, 4'd1);
    expect_out("ss_latency_run", 2'd1, 1'b1, 1'b0, 4'd2, 4'd1);
    btn_ss = 1'b1;
    tick(7);
    check_out();
    tick(1);
    check_out();
    tick(2);
    btn_ss = 1'b0;
    tick(10);
    expect_out("ss_held_one_pulse", 2'd1, 1'b1, 1'b0, 4'd2, 4'd1);
    check_out();

    expect_out("glitch_3cy", 2'd1, 1'b1, 1'b0, 4'd2, 4'd1);
    btn_ss = 1'b1;
    tick(3);
    btn_ss = 1'b0;
    tick(10);
    check_out();

    // Lap capture and release.
    d1_in = 4'd3; d0_in = 4'd7;
    expect_out("lap_enter", 2'd3, 1'b1, 1'b0, 4'd3, 4'd7);
    press(1'b0, 1'b1);
    check_out();
    d1_in = 4'd4; d0_in = 4'd2;
    expect_out("lap_frozen", 2'd3, 1'b1, 1'b0, 4'd3, 4'd7);
    expect_out("lap_frozen_later", 2'd3, 1'b1, 1'b0, 4'd3, 4'd7);
    #1;
    check_out();
    tick(5);
    check_out();
    expect_out("lap_release", 2'd1, 1'b1, 1'b0, 4'd4, 4'd2);
    press(1'b0, 1'b1);
    check_out();

    expect_out("pause", 2'd2, 1'b0, 1'b0, 4'd4, 4'd2);
    press(1'b1, 1'b0);
    check_out();

    // Clear from PAUSE: one clr cycle on the acting edge.
    expect_out("clr_pre", 2'd2, 1'b0, 1'b0, 4'd4, 4'd2);
    expect_out("clr_pulse", 2'd0, 1'b0, 1'b1, 4'd4, 4'd2);
    expect_out("clr_done", 2'd0, 1'b0, 1'b0, 4'd4, 4'd2);
    btn_lc = 1'b1;
    tick(7);
    check_out();
    tick(1);
    check_out();
    tick(1);
    check_out();
    tick(1);
    btn_lc = 1'b0;
    tick(10);

    // Clear in IDLE also pulses clr and stays IDLE.
    expect_out("idle_clr_pulse", 2'd0, 1'b0, 1'b1, 4'd4, 4'd2);
    expect_out("idle_clr_done", 2'd0, 1'b0, 1'b0, 4'd4, 4'd2);
    btn_lc = 1'b1;
    tick(8);
    check_out();
    tick(1);
    check_out();
    tick(1);
    btn_lc = 1'b0;
    tick(10);

    expect_out("run_again", 2'd1, 1'b1, 1'b0, 4'd4, 4'd2);
    press(1'b1, 1'b0);
    check_out();

    // Both buttons together: start/stop wins.
    d1_in = 4'd5; d0_in = 4'd5;
    expect_out("both_pause", 2'd2, 1'b0, 1'b0, 4'd5, 4'd5);
    press(1'b1, 1'b1);
    check_out();

    expect_out("resume", 2'd1, 1'b1, 1'b0, 4'd5, 4'd5);
    press(1'b1, 1'b0);
    check_out();
    d1_in = 4'd1; d0_in = 4'd2;
    expect_out("lap_again", 2'd3, 1'b1, 1'b0, 4'd1, 4'd2);
    press(1'b0, 1'b1);
    check_out();

    // Asynchronous reset in LAP, checked between clock edges.
    d1_in = 4'd1; d0_in = 4'd3;
    #1;
    res = 1'b1;
    expect_out("reset_in_lap", 2'd0, 1'b0, 1'b1, 4'd1, 4'd3);
    #2;
    check_out();
    tick(2);
    res = 1'b0;
    expect_out("post_reset", 2'd0, 1'b0, 1'b0, 4'd1, 4'd3);
    tick(1);
    check_out();

    // Count reaching 99 while running.
    d1_in = 4'd9; d0_in = 4'd8;
    expect_out("run_98", 2'd1, 1'b1, 1'b0, 4'd9, 4'd8);
    press(1'b1, 1'b0);
    check_out();
    d1_in = 4'd9; d0_in = 4'd9;
`ifdef STOPWATCH_AUTOSTOP_EN
    expect_out("autostop_99", 2'd2, 1'b0, 1'b0, 4'd9, 4'd9);
    expect_out("autostop_hold", 2'd2, 1'b0, 1'b0, 4'd9, 4'd9);
`else
    expect_out("no_autostop_99", 2'd1, 1'b1, 1'b0, 4'd9, 4'd9);
    expect_out("no_autostop_hold", 2'd1, 1'b1, 1'b0, 4'd9, 4'd9);
`endif
    tick(1);
    check_out();
    tick(3);
    check_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Front-panel controller for the two-digit seconds stopwatch counter.
- Takes two raw push-buttons (start/stop, lap/clear), then synchronises, debounces and edge-detects them.
- Runs a 4-state FSM that drives the counter's go and clear inputs.
- Muxes live or lap-frozen digits to the display.
- Sits between board buttons and the counter/7-seg driver, in the 25 MHz domain.

Parameters:
- DB_CYCLES, 250000, consecutive stable cycles required to accept a button level (10 ms at 25 MHz).
- DB_W, 18, width of the debounce counter; must hold DB_CYCLES.

Ports:
- clk  in  1  system clock, 25 MHz.
- res  in  1  asynchronous, active-high reset.
- btn_ss  in  1  raw start/stop button, active-high, asynchronous to clk.
- btn_lc  in  1  raw lap/clear button, active-high, asynchronous to clk.
- d1_in  in  4  live tens digit from counter, 0-9.
- d0_in  in  4  live units digit from counter, 0-9.
- go  out  1  counter enable, registered.
- clr  out  1  counter synchronous clear, registered one-cycle pulse.
- disp1  out  4  tens digit to display.
- disp0  out  4  units digit to display.
- state  out  2  FSM state for LEDs: IDLE=0, RUN=1, PAUSE=2, LAP=3.

Behaviour:
- Reset (async, res=1): state=IDLE, go=0, clr=1, lap_d1=lap_d0=0, debounce counters=0, stable levels=0, sync flops=0.
- First clk edge after res deasserts: clr=0. The counter therefore sees one clear cycle after every reset.
- Per button, synchroniser: 2-FF synchroniser on the raw input.
- Per button, debounce:
  - cnt resets to 0 whenever synced level == stable.
  - Otherwise cnt increments.
  - When cnt == DB_CYCLES-1 and the level still differs: stable <= synced, cnt <= 0.
  - A glitch shorter than DB_CYCLES cycles never changes stable.
- Edge detect: pulse ss_p / lc_p high for exactly 1 cycle, the cycle after stable rises 0->1. Falling edges produce nothing.
- Priority: if ss_p and lc_p are asserted in the same cycle, ss_p is acted on and lc_p is discarded.
- FSM transitions, all registered:
  - IDLE: ss_p -> RUN. lc_p -> stay IDLE, clr pulse.
  - RUN: ss_p -> PAUSE. lc_p -> LAP, capturing lap_d1<=d1_in and lap_d0<=d0_in in the same edge.
  - LAP: ss_p -> PAUSE (frozen display released). lc_p -> RUN (display released).
  - PAUSE: ss_p -> RUN. lc_p -> IDLE, clr pulse.
- go is registered: go=1 exactly when the next state is RUN or LAP. It changes on the same edge as state, one cycle after the pulse.
- The counter keeps counting while in LAP.
- clr is high for exactly one cycle, on the edge the FSM acts on the lc_p that causes the clear. It is never asserted in RUN or LAP.
- Display mux, combinational from registered sources:
  - state==LAP: disp = lap_d*.
  - Otherwise: disp = d*_in.
- Digits are passed through unmodified; no width change.
- Reset mid-operation (any state, any debounce progress) returns to IDLE immediately, with clr asserted as above.
- Button held down: only one pulse per press. Auto-repeat is not supported.

Optional Feature:
- Macro: STOPWATCH_AUTOSTOP_EN.
- Defined:
  - In RUN or LAP, when d1_in==9 and d0_in==9, the FSM moves to PAUSE on the next edge and go drops there.
  - The display shows 99 (released from lap).
  - A simultaneous ss_p has priority; ss_p in RUN also yields PAUSE.
- Undefined: no check; the counter wraps 99->00 and the FSM stays in its state.

Test Plan:
- Assert res, release: state=0, go=0, clr=1 for exactly 1 cycle after release, disp=d_in.
- DB_CYCLES=4. Press btn_ss for 10 cycles from IDLE: go=1, state=1 exactly 2 sync + 4 debounce + 1 edge + 1 state cycles after the press. A 3-cycle glitch on btn_ss causes no change.
- RUN with d1_in=3, d0_in=7, press btn_lc:
  - state=3, disp=3/7 held while d_in advances to 4/2, go stays 1.
  - Press btn_lc again: state=1, disp=4/2.
- RUN -> ss press -> PAUSE (go=0) -> lc press: state=0, one clr pulse, go=0.
- Same-cycle stable rise on both buttons in RUN: state=PAUSE, no lap capture. Async res asserted in LAP: outputs at reset values without waiting for a clk edge.
- STOPWATCH_AUTOSTOP_EN defined, RUN with d_in stepping 9/8 -> 9/9: next edge state=2, go=0, disp=9/9. Without the macro: state stays 1 at 9/9.
